// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity bit, one stop bit.
// One bit per CLK cycle; back-to-back frames may be accepted during the stop bit.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  TX_READY
);

    localparam int unsigned            CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    par_en_q;
    logic                    par_typ_q;

    // Outputs are computed together with the next state so they describe the bit on the line.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            BUSY      <= 1'b0;
            TX_READY  <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (DATA_VALID && TX_READY) begin
                        state     <= START;
                        shift_reg <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        bit_cnt   <= '0;
                        TX_OUT    <= 1'b0;
                        BUSY      <= 1'b1;
                        TX_READY  <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        TX_OUT   <= 1'b1;
                        BUSY     <= 1'b0;
                        TX_READY <= 1'b1;
                    end
                end
                START: begin
                    state  <= DATA;
                    TX_OUT <= shift_reg[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            // Rotation preserves the XOR of the payload, so parity is still exact here.
                            TX_OUT <= (^shift_reg) ^ par_typ_q;
                        end else begin
                            state    <= STOP;
                            TX_OUT   <= 1'b1;
                            TX_READY <= 1'b1;
                        end
                    end else begin
                        shift_reg <= {shift_reg[0], shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        TX_OUT    <= shift_reg[1];
                    end
                end
                PARITY: begin
                    state    <= STOP;
                    TX_OUT   <= 1'b1;
                    TX_READY <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    TX_OUT   <= 1'b1;
                    BUSY     <= 1'b0;
                    TX_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal range 5..9).
REQ-002 SHALL have port CLK  input  1  bit-rate clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  request to transmit P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port TX_OUT  output  1  serial line, idle high, registered.
REQ-009 SHALL have port BUSY  output  1  high while a frame is on the line, registered.
REQ-010 SHALL have port TX_READY  output  1  high when DATA_VALID will be accepted this cycle.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; exactly one bit per CLK cycle per state slot.
REQ-012 SHALL drive TX_OUT per current state: IDLE=1, START=0, DATA=current payload bit, PARITY=parity bit, STOP=1.
REQ-013 SHALL drive BUSY=0 in IDLE, BUSY=1 in START, DATA, PARITY, STOP.
REQ-014 SHALL drive TX_READY=1 in IDLE and STOP, 0 otherwise.
REQ-015 SHALL accept a request when DATA_VALID=1 and TX_READY=1 at a rising edge; the next cycle is START.
REQ-016 SHALL, on acceptance, latch P_DATA into a shift register and latch PAR_EN and PAR_TYP; later changes to these inputs do not affect the frame in flight.
REQ-017 SHALL ignore DATA_VALID while TX_READY=0; no queuing, no effect on the current frame.
REQ-018 SHALL transmit the payload LSB first over exactly DATA_WIDTH consecutive DATA cycles, counted by a bit counter of width ceil(log2(DATA_WIDTH)).
REQ-019 SHALL transition START->DATA after 1 cycle; DATA->PARITY after the last data bit if latched PAR_EN=1, otherwise DATA->STOP.
REQ-020 SHALL transition PARITY->STOP after 1 cycle.
REQ-021 SHALL compute parity from the latched payload: even = XOR of all bits; odd = inverse of that XOR.
REQ-022 SHALL, in STOP, go to START if a request is accepted that cycle (gapless back-to-back), otherwise to IDLE.
REQ-023 SHALL have a frame length of 2+DATA_WIDTH+PAR_EN cycles measured from the START cycle to the STOP cycle inclusive.
REQ-024 SHALL remain in IDLE with TX_OUT=1 indefinitely while no request is accepted.

Reset
REQ-025 SHALL, with RST=1 at a rising edge, force state IDLE, TX_OUT=1, BUSY=0, TX_READY=1, shift register=0, bit counter=0, latched parity config=0.
REQ-026 SHALL abort any frame in flight on reset; no remaining bits are sent.
REQ-027 SHALL give RST priority over DATA_VALID at the same edge; the request is dropped.
REQ-028 SHALL accept a new request in the first cycle after RST deasserts.

Verification
REQ-029 SHALL cover: RST=1 for 2 cycles with DATA_VALID=1 -> TX_OUT=1, BUSY=0, TX_READY=1 throughout; no frame starts.
REQ-030 SHALL cover: P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; BUSY=1 for exactly those 10 cycles; then idle.
REQ-031 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> 11-bit frame with parity bit 0; repeat with PAR_TYP=1 -> parity bit 1.
REQ-032 SHALL cover: 0x3C sent, then 0xC3 presented with DATA_VALID=1 in the STOP cycle (PAR_EN=0) -> START of the second frame in the next cycle; BUSY=1 for 20 consecutive cycles; TX_OUT = 0,00111100,1,0,11000011,1 (each payload LSB first).
REQ-033 SHALL cover: during the DATA state of 0xA5, drive P_DATA=0xFF, PAR_EN toggled, DATA_VALID=1 -> frame bits unchanged and no extra frame follows.
REQ-034 SHALL cover: RST=1 in the 3rd DATA cycle -> next cycle TX_OUT=1, BUSY=0; a subsequent 0x55 request (PAR_EN=0) -> a complete, correct 10-bit frame.
